mem_access_unit: RTL and testbench

Memory-stage access controller sitting directly downstream of the EXE/MEM register and consuming the EXE ALU result as the effective address. It turns load/store instructions into a request/acknowledge transaction on the data-memory port. It stalls the pipeline while the transaction is outstanding. It returns size-aligned, sign- or zero-extended load data to the MEM/WB register.

---
 rtl/mem_access_unit.sv | 182 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store controller driving a req/ack data-memory port.
// Optional macro MEM_ALIGN_CHECK_EN faults misaligned halfword/word accesses without a request.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        Valid_IN,
    input  logic        MemRead_IN,
    input  logic        MemWrite_IN,
    input  logic [1:0]  MemSize_IN,
    input  logic        MemSigned_IN,
    input  logic [31:0] Address_IN,
    input  logic [31:0] StoreData_IN,
    output logic        DMemReq_OUT,
    output logic        DMemWE_OUT,
    output logic [31:0] DMemAddr_OUT,
    output logic [3:0]  DMemByteEn_OUT,
    output logic [31:0] DMemWData_OUT,
    input  logic        DMemAck_IN,
    input  logic [31:0] DMemRData_IN,
    output logic [31:0] LoadData_OUT,
    output logic        Done_OUT,
    output logic        Stall_OUT,
    output logic        Timeout_OUT,
    output logic        Misaligned_OUT
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] cnt_q, cnt_d;
    logic        tmo_q, tmo_d;
    logic        mis_q, mis_d;

    logic        mem_op;
    logic [3:0]  be_new;
    logic [31:0] wd_new;
    logic        misal_new;

    // Big-endian lane selection: offset 0 is bits 31:24.
    function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] a,
                                                input logic [1:0] sz, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = a[1] ? w[15:0] : w[31:16];
        case (sz)
            2'b00:   load_extend = sgn ? {{24{b[7]}}, b} : {24'd0, b};
            2'b01:   load_extend = sgn ? {{16{h[15]}}, h} : {16'd0, h};
            default: load_extend = w;
        endcase
    endfunction

    // Gating with RESET keeps Stall_OUT low while reset is held, even with a live op on the inputs.
    assign mem_op = RESET & Valid_IN & (MemRead_IN | MemWrite_IN);

    always_comb begin
        be_new    = 4'b1111;
        wd_new    = StoreData_IN;
        misal_new = 1'b0;
        case (MemSize_IN)
            2'b00: begin
                be_new = 4'b1000 >> Address_IN[1:0];
                wd_new = {4{StoreData_IN[7:0]}};
            end
            2'b01: begin
                be_new = Address_IN[1] ? 4'b0011 : 4'b1100;
                wd_new = {2{StoreData_IN[15:0]}};
            end
            default: begin
                be_new = 4'b1111;
                wd_new = StoreData_IN;
            end
        endcase
`ifdef MEM_ALIGN_CHECK_EN
        misal_new = ((MemSize_IN == 2'b01) && Address_IN[0]) ||
                    (MemSize_IN[1] && (Address_IN[1:0] != 2'b00));
`endif
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        mis_d   = mis_q;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    addr_d  = Address_IN;
                    we_d    = MemWrite_IN;
                    size_d  = MemSize_IN;
                    sgn_d   = MemSigned_IN;
                    be_d    = be_new;
                    wdata_d = wd_new;
                    rdata_d = 32'd0;
                    cnt_d   = 16'd0;
                    tmo_d   = 1'b0;
                    mis_d   = misal_new;
                    state_d = misal_new ? DONE : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (DMemAck_IN) begin
                    if (!we_q) rdata_d = DMemRData_IN;
                    state_d = DONE;
                end else if ((TMO != 16'd0) && (cnt_q + 16'd1 == TMO)) begin
                    tmo_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                tmo_d   = 1'b0;
                mis_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            cnt_q   <= 16'd0;
            tmo_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            mis_q   <= mis_d;
        end
    end

    assign DMemReq_OUT    = (state_q == WAIT);
    assign Stall_OUT      = (state_q == WAIT) | ((state_q == IDLE) & mem_op);
    assign DMemWE_OUT     = we_q;
    assign DMemAddr_OUT   = {addr_q[31:2], 2'b00};
    assign DMemByteEn_OUT = be_q;
    assign DMemWData_OUT  = wdata_q;
    assign Done_OUT       = (state_q == DONE);
    assign Timeout_OUT    = Done_OUT & tmo_q;
    assign Misaligned_OUT = Done_OUT & mis_q;
    // rdata_q is cleared on accept, so timeouts, faults and stores all return 0.
    assign LoadData_OUT   = Done_OUT ? load_extend(rdata_q, addr_q[1:0], size_q, sgn_q) : 32'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit (TIMEOUT_CYCLES = 4).
module tb_mem_access_unit;
    logic        CLOCK;
    logic        RESET;
    logic        Valid_IN, MemRead_IN, MemWrite_IN, MemSigned_IN;
    logic [1:0]  MemSize_IN;
    logic [31:0] Address_IN, StoreData_IN;
    logic        DMemReq_OUT, DMemWE_OUT;
    logic [31:0] DMemAddr_OUT, DMemWData_OUT;
    logic [3:0]  DMemByteEn_OUT;
    logic        DMemAck_IN;
    logic [31:0] DMemRData_IN;
    logic [31:0] LoadData_OUT;
    logic        Done_OUT, Stall_OUT, Timeout_OUT, Misaligned_OUT;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] mem [logic [31:0]];

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .Valid_IN(Valid_IN), .MemRead_IN(MemRead_IN), .MemWrite_IN(MemWrite_IN),
        .MemSize_IN(MemSize_IN), .MemSigned_IN(MemSigned_IN),
        .Address_IN(Address_IN), .StoreData_IN(StoreData_IN),
        .DMemReq_OUT(DMemReq_OUT), .DMemWE_OUT(DMemWE_OUT), .DMemAddr_OUT(DMemAddr_OUT),
        .DMemByteEn_OUT(DMemByteEn_OUT), .DMemWData_OUT(DMemWData_OUT),
        .DMemAck_IN(DMemAck_IN), .DMemRData_IN(DMemRData_IN),
        .LoadData_OUT(LoadData_OUT), .Done_OUT(Done_OUT), .Stall_OUT(Stall_OUT),
        .Timeout_OUT(Timeout_OUT), .Misaligned_OUT(Misaligned_OUT)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        rd, wr;
        logic [1:0]  sz;
        logic        sgn;
        logic [31:0] addr, sdata;
        int          ack_at;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_load;
        logic        e_tmo, e_mis;
        int          e_reqs, e_done;
    } vec_t;

    function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] sz,
                                input logic sgn, input logic [31:0] addr, input logic [31:0] sdata,
                                input int ack_at, input logic [31:0] e_addr, input logic [3:0] e_be,
                                input logic [31:0] e_wdata, input logic [31:0] e_load,
                                input logic e_tmo, input logic e_mis, input int e_reqs, input int e_done);
        vec_t v;
        v.rd = rd; v.wr = wr; v.sz = sz; v.sgn = sgn; v.addr = addr; v.sdata = sdata;
        v.ack_at = ack_at; v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata;
        v.e_load = e_load; v.e_tmo = e_tmo; v.e_mis = e_mis; v.e_reqs = e_reqs; v.e_done = e_done;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        Valid_IN = 1'b0; MemRead_IN = 1'b0; MemWrite_IN = 1'b0; MemSize_IN = 2'b00;
        MemSigned_IN = 1'b0; Address_IN = 32'd0; StoreData_IN = 32'd0; DMemAck_IN = 1'b0;
    endtask

    // Caller positions time just after a rising edge; that cycle is cycle 0 of the op.
    task automatic run_op(input vec_t v, input string tag);
        int stall_n, req_n, cyc;
        bit done_seen;
        logic [31:0] w;
        Valid_IN = 1'b1; MemRead_IN = v.rd; MemWrite_IN = v.wr; MemSize_IN = v.sz;
        MemSigned_IN = v.sgn; Address_IN = v.addr; StoreData_IN = v.sdata; DMemAck_IN = 1'b0;
        stall_n = 0; req_n = 0; cyc = 0; done_seen = 0;
        while (!done_seen && cyc < 40) begin
            @(negedge CLOCK);
            if (Stall_OUT) stall_n++;
            if (cyc == 0) begin
                chk({tag, "_c0_stall"}, Stall_OUT, 1);
                chk({tag, "_c0_req"}, DMemReq_OUT, 0);
                chk({tag, "_c0_done"}, Done_OUT, 0);
            end
            if (DMemReq_OUT) begin
                req_n++;
                if (req_n == 1) begin
                    chk({tag, "_addr"}, DMemAddr_OUT, v.e_addr);
                    chk({tag, "_be"}, DMemByteEn_OUT, v.e_be);
                    chk({tag, "_we"}, DMemWE_OUT, v.wr);
                    if (v.wr) chk({tag, "_wdata"}, DMemWData_OUT, v.e_wdata);
                end
                DMemRData_IN = mem.exists(DMemAddr_OUT) ? mem[DMemAddr_OUT] : 32'd0;
                DMemAck_IN = (v.ack_at != 0) && (req_n == v.ack_at);
                if (DMemAck_IN && DMemWE_OUT) begin
                    w = DMemRData_IN;
                    for (int i = 0; i < 4; i++)
                        if (DMemByteEn_OUT[i]) w[8*i +: 8] = DMemWData_OUT[8*i +: 8];
                    mem[DMemAddr_OUT] = w;
                end
            end else begin
                DMemAck_IN = 1'b0;
            end
            if (Done_OUT) begin
                done_seen = 1;
                chk({tag, "_done_cyc"}, cyc, v.e_done);
                chk({tag, "_stall_cycles"}, stall_n, v.e_done);
                chk({tag, "_req_cycles"}, req_n, v.e_reqs);
                chk({tag, "_load"}, LoadData_OUT, v.e_load);
                chk({tag, "_timeout"}, Timeout_OUT, v.e_tmo);
                chk({tag, "_misaligned"}, Misaligned_OUT, v.e_mis);
                chk({tag, "_done_stall"}, Stall_OUT, 0);
            end else begin
                cyc++;
            end
        end
        if (!done_seen) chk({tag, "_done_seen"}, 0, 1);
        DMemAck_IN = 1'b0;
    endtask

    vec_t vecs[$];
    vec_t v;

    initial begin
        idle_inputs();
        DMemRData_IN = 32'd0;
        RESET = 1'b0;
        mem[32'h100] = 32'h11AA2233;
        mem[32'h200] = 32'h80017F00;
        mem[32'h400] = 32'hDEADBEEF;
        mem[32'h404] = 32'hCAFEF00D;
        mem[32'h000] = 32'h01020304;

        vecs.push_back(mk(1,0,2'b00,1,32'h102,0,1,32'h100,4'b0010,0,32'h00000022,0,0,1,2));
        vecs.push_back(mk(1,0,2'b00,1,32'h101,0,1,32'h100,4'b0100,0,32'hFFFFFFAA,0,0,1,2));
        vecs.push_back(mk(1,0,2'b00,0,32'h101,0,1,32'h100,4'b0100,0,32'h000000AA,0,0,1,2));
        vecs.push_back(mk(1,0,2'b00,1,32'h103,0,1,32'h100,4'b0001,0,32'h00000033,0,0,1,2));
        vecs.push_back(mk(1,0,2'b01,1,32'h200,0,2,32'h200,4'b1100,0,32'hFFFF8001,0,0,2,3));
        vecs.push_back(mk(1,0,2'b01,0,32'h202,0,1,32'h200,4'b0011,0,32'h00007F00,0,0,1,2));
        vecs.push_back(mk(0,1,2'b01,0,32'h206,32'h0000BEEF,3,32'h204,4'b0011,32'hBEEFBEEF,0,0,0,3,4));
        vecs.push_back(mk(0,1,2'b00,0,32'h303,32'h12345678,1,32'h300,4'b0001,32'h78787878,0,0,0,1,2));
        vecs.push_back(mk(1,0,2'b10,0,32'h400,0,0,32'h400,4'b1111,0,32'h0,1,0,4,5));
        vecs.push_back(mk(1,0,2'b10,0,32'h404,0,4,32'h404,4'b1111,0,32'hCAFEF00D,0,0,4,5));
`ifdef MEM_ALIGN_CHECK_EN
        vecs.push_back(mk(1,0,2'b10,0,32'h003,0,1,32'h0,4'b0000,0,32'h0,0,1,0,1));
`else
        vecs.push_back(mk(1,0,2'b10,0,32'h003,0,1,32'h0,4'b1111,0,32'h01020304,0,0,1,2));
`endif
        vecs.push_back(mk(1,0,2'b11,0,32'h404,0,2,32'h404,4'b1111,0,32'hCAFEF00D,0,0,2,3));
        vecs.push_back(mk(1,1,2'b10,0,32'h500,32'hA5A55A5A,1,32'h500,4'b1111,32'hA5A55A5A,0,0,0,1,2));
        vecs.push_back(mk(1,0,2'b10,0,32'h500,0,1,32'h500,4'b1111,0,32'hA5A55A5A,0,0,1,2));
        vecs.push_back(mk(1,0,2'b00,0,32'h303,0,1,32'h300,4'b0001,0,32'h00000078,0,0,1,2));

        // Reset state, including a live op held on the inputs.
        #12;
        chk("rst_req", DMemReq_OUT, 0);
        chk("rst_we", DMemWE_OUT, 0);
        chk("rst_addr", DMemAddr_OUT, 0);
        chk("rst_be", DMemByteEn_OUT, 0);
        chk("rst_wdata", DMemWData_OUT, 0);
        chk("rst_load", LoadData_OUT, 0);
        chk("rst_done", Done_OUT, 0);
        chk("rst_timeout", Timeout_OUT, 0);
        chk("rst_mis", Misaligned_OUT, 0);
        Valid_IN = 1'b1; MemRead_IN = 1'b1; #1;
        chk("rst_stall_live_op", Stall_OUT, 0);
        idle_inputs();
        @(negedge CLOCK); RESET = 1'b1;

        // Non-memory instruction with a stray ack: no stall, no request, no pulse.
        @(posedge CLOCK); #1;
        Valid_IN = 1'b1; DMemAck_IN = 1'b1;
        @(negedge CLOCK);
        chk("nonmem_stall", Stall_OUT, 0);
        @(posedge CLOCK); #1; idle_inputs();
        @(negedge CLOCK);
        chk("nonmem_req", DMemReq_OUT, 0);
        chk("nonmem_done", Done_OUT, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge CLOCK); #1;
            run_op(vecs[i], $sformatf("v%0d", i));
            @(posedge CLOCK); #1; idle_inputs();
            @(negedge CLOCK);
            chk($sformatf("v%0d_pulse_end", i), Done_OUT, 0);
            chk($sformatf("v%0d_idle_stall", i), Stall_OUT, 0);
        end

        // Reset asserted in the second WAIT cycle with the op still presented.
        @(posedge CLOCK); #1;
        Valid_IN = 1'b1; MemRead_IN = 1'b1; MemSize_IN = 2'b10; Address_IN = 32'h404;
        @(posedge CLOCK); #1;
        @(posedge CLOCK); #1;
        chk("rstw_req_before", DMemReq_OUT, 1);
        #2; RESET = 1'b0; #1;
        chk("rstw_req", DMemReq_OUT, 0);
        chk("rstw_stall", Stall_OUT, 0);
        chk("rstw_done", Done_OUT, 0);
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            @(negedge CLOCK);
            chk("rstw_hold_done", Done_OUT, 0);
        end
        RESET = 1'b1;
        @(negedge CLOCK);
        chk("rstw_after_done", Done_OUT, 0);
        @(posedge CLOCK); #1;
        v = mk(1,0,2'b10,0,32'h404,0,1,32'h404,4'b1111,0,32'hCAFEF00D,0,0,1,2);
        run_op(v, "rstw_lw");

        // Back-to-back SW then LW with immediate acks; LW is accepted in the IDLE cycle after DONE.
        @(posedge CLOCK); #1; idle_inputs();
        @(posedge CLOCK); #1;
        v = mk(0,1,2'b10,0,32'h10,32'h5EED1234,1,32'h10,4'b1111,32'h5EED1234,0,0,0,1,2);
        run_op(v, "b2b_sw");
        @(posedge CLOCK); #1;
        v = mk(1,0,2'b10,0,32'h10,0,1,32'h10,4'b1111,0,32'h5EED1234,0,0,1,2);
        run_op(v, "b2b_lw");
        @(posedge CLOCK); #1; idle_inputs();

        repeat (2) @(posedge CLOCK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
